// File: rtl/morph_stream_kxk_if.sv
// Pixel-stream bundle for morph_stream_kxk: input beats (with mode/SOF) and
// valid-only result beats carrying SOF/EOF framing.
interface morph_stream_kxk_if #(
  parameter int DATA_W = 8
);
  logic              mode;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_sof;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_sof;
  logic              out_eof;

  modport master (
    output mode, in_valid, in_data, in_sof,
    input  out_valid, out_data, out_sof, out_eof
  );

  modport slave (
    input  mode, in_valid, in_data, in_sof,
    output out_valid, out_data, out_sof, out_eof
  );
endinterface

// File: rtl/morph_stream_kxk.sv
// Streaming KxK grey-scale dilate/erode: K-1 line buffers feed a KxK window,
// reduced by a balanced max/min tree into a registered, valid-only output.
module morph_stream_kxk #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int K      = 5
) (
  input logic               clk,
  input logic               rst,
  morph_stream_kxk_if.slave bus
);
  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);
  localparam int N   = K * K;
  localparam int P   = 1 << $clog2(N);

  logic              accept;
  logic [CW-1:0]     cur_col, col_q, col_d;
  logic [RW-1:0]     cur_row, row_q, row_d;
  logic              qual, at_first, at_last;
  logic              mode_q;
  logic [DATA_W-1:0] lb_rd  [K-1];
  logic [DATA_W-1:0] column [K];
  logic [DATA_W-1:0] win_q  [K][K];
  logic [DATA_W-1:0] red;
  logic              v1_q, sof1_q, eof1_q;
  logic              out_valid_q, out_sof_q, out_eof_q;
  logic [DATA_W-1:0] out_data_q;

  // An SOF beat is always treated as position (0,0), whatever the counters say.
  always_comb begin
    accept   = bus.in_valid;
    cur_col  = bus.in_sof ? '0 : col_q;
    cur_row  = bus.in_sof ? '0 : row_q;
    col_d    = col_q;
    row_d    = row_q;
    if (accept) begin
      if (cur_col == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
    end
    qual     = accept && (cur_row >= RW'(K - 1)) && (cur_col >= CW'(K - 1));
    at_first = (cur_row == RW'(K - 1)) && (cur_col == CW'(K - 1));
    at_last  = (cur_row == RW'(IMG_H - 1)) && (cur_col == CW'(IMG_W - 1));
  end

  // Buffer 0 holds the previous line; each deeper buffer takes the line its
  // neighbour is evicting. Asynchronous read gives read-before-write per beat.
  for (genvar gi = 0; gi < K - 1; gi++) begin : g_lb
    logic [DATA_W-1:0] mem [IMG_W];
    logic [DATA_W-1:0] wr_data;
    if (gi == 0) begin : g_head
      assign wr_data = bus.in_data;
    end else begin : g_tail
      assign wr_data = lb_rd[gi-1];
    end
    assign lb_rd[gi] = mem[cur_col];
    always_ff @(posedge clk) begin
      if (accept) mem[cur_col] <= wr_data;
    end
  end

  // Window row 0 is the oldest line, row K-1 the incoming one.
  for (genvar gi = 0; gi < K - 1; gi++) begin : g_col
    assign column[gi] = lb_rd[K-2-gi];
  end
  assign column[K-1] = bus.in_data;

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) win_q[r][c] <= win_q[r][c+1];
        win_q[r][K-1] <= column[r];
      end
    end
  end

  // Pairwise halving tree; padding leaves repeat a real pixel so they are
  // neutral for both max and min.
  always_comb begin : reduce_tree
    logic [DATA_W-1:0] lvl [P];
    for (int i = 0; i < P; i++) lvl[i] = (i < N) ? win_q[i / K][i % K] : win_q[0][0];
    for (int s = P / 2; s >= 1; s = s / 2) begin
      for (int i = 0; i < s; i++) begin
        if (mode_q) lvl[i] = (lvl[2*i+1] < lvl[2*i]) ? lvl[2*i+1] : lvl[2*i];
        else        lvl[i] = (lvl[2*i+1] > lvl[2*i]) ? lvl[2*i+1] : lvl[2*i];
      end
    end
    red = lvl[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      mode_q      <= 1'b0;
      v1_q        <= 1'b0;
      sof1_q      <= 1'b0;
      eof1_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      if (accept && bus.in_sof) mode_q <= bus.mode;
      v1_q        <= qual;
      sof1_q      <= qual && at_first;
      eof1_q      <= qual && at_last;
      out_valid_q <= v1_q;
      out_sof_q   <= sof1_q;
      out_eof_q   <= eof1_q;
      if (v1_q) out_data_q <= red;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sof   = out_sof_q;
  assign bus.out_eof   = out_eof_q;
endmodule

// File: tb/tb_morph_stream_kxk.sv
// Bench for morph_stream_kxk: a K=3 8x6 instance and a K=5 10x7 instance,
// checked against a windowed max/min model computed straight from the frame.
module tb_morph_stream_kxk;
  localparam int DW = 8;
  localparam int W3 = 8,  H3 = 6, K3 = 3;
  localparam int W5 = 10, H5 = 7, K5 = 5;

  typedef struct {
    int data;
    bit sof;
    bit eof;
    int idx;
    int edge_n;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  morph_stream_kxk_if #(.DATA_W(DW)) b3 ();
  morph_stream_kxk_if #(.DATA_W(DW)) b5 ();

  morph_stream_kxk #(.DATA_W(DW), .IMG_W(W3), .IMG_H(H3), .K(K3)) dut3 (
    .clk(clk), .rst(rst), .bus(b3.slave));
  morph_stream_kxk #(.DATA_W(DW), .IMG_W(W5), .IMG_H(H5), .K(K5)) dut5 (
    .clk(clk), .rst(rst), .bus(b5.slave));

  out_t obs3[$], obs5[$], exp_q[$];
  int   beats3[$], beats5[$];
  int   frame_q[$];
  int   edge_n = 0;
  int   stray = 0;
  int   checks = 0;
  int   errors = 0;

  // Logs accepted beats per edge and output beats just after the edge.
  always @(posedge clk) begin
    edge_n++;
    if (!rst && b3.in_valid) beats3.push_back(edge_n);
    if (!rst && b5.in_valid) beats5.push_back(edge_n);
    #1;
    if (b3.out_valid) obs3.push_back('{int'(b3.out_data), b3.out_sof, b3.out_eof, 0, edge_n});
    else if (b3.out_sof || b3.out_eof) stray++;
    if (b5.out_valid) obs5.push_back('{int'(b5.out_data), b5.out_sof, b5.out_eof, 0, edge_n});
    else if (b5.out_sof || b5.out_eof) stray++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_in(input bit sel, input bit v, input int d, input bit s, input bit m);
    if (sel) begin
      b5.in_valid = v; b5.in_data = DW'(d); b5.in_sof = s; b5.mode = m;
    end else begin
      b3.in_valid = v; b3.in_data = DW'(d); b3.in_sof = s; b3.mode = m;
    end
  endtask

  // Mode input is the wanted mode only on the SOF beat and inverted elsewhere.
  task automatic drive(input bit sel, input bit md, input bit first_sof,
                       input int gap_pct, input int base, input int n);
    for (int i = 0; i < n; i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        @(negedge clk);
        set_in(sel, 1'b0, $urandom_range(255), 1'($urandom_range(1)), 1'($urandom_range(1)));
      end
      @(negedge clk);
      set_in(sel, 1'b1, frame_q[base+i], first_sof && i == 0,
             (first_sof && i == 0) ? md : !md);
    end
    @(negedge clk);
    set_in(sel, 1'b0, 0, 1'b0, 1'b0);
  endtask

  // Every full KxK window inside the first `limit` pixels of the frame at `base`.
  function automatic void build_expected(input int w, input int h, input int k,
                                         input bit md, input int base, input int limit);
    int v, p;
    for (int r = k - 1; r < h; r++) begin
      for (int c = k - 1; c < w; c++) begin
        if (r * w + c < limit) begin
          v = frame_q[base + (r-k+1)*w + (c-k+1)];
          for (int dr = 0; dr < k; dr++)
            for (int dc = 0; dc < k; dc++) begin
              p = frame_q[base + (r-k+1+dr)*w + (c-k+1+dc)];
              if (md ? (p < v) : (p > v)) v = p;
            end
          exp_q.push_back('{v, (r == k-1 && c == k-1), (r == h-1 && c == w-1), base + r*w + c, 0});
        end
      end
    end
  endfunction

  task automatic test_reset();
    set_in(1'b0, 1'b0, 0, 1'b0, 1'b0);
    set_in(1'b1, 1'b0, 0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 8;
    if (b3.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid3: got %b required 0", b3.out_valid); end
    if (b3.out_data !== 8'd0)  begin errors++; $display("FAIL reset_data3: got %0d required 0", b3.out_data); end
    if (b3.out_sof !== 1'b0)   begin errors++; $display("FAIL reset_sof3: got %b required 0", b3.out_sof); end
    if (b3.out_eof !== 1'b0)   begin errors++; $display("FAIL reset_eof3: got %b required 0", b3.out_eof); end
    if (b5.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid5: got %b required 0", b5.out_valid); end
    if (b5.out_data !== 8'd0)  begin errors++; $display("FAIL reset_data5: got %0d required 0", b5.out_data); end
    if (b5.out_sof !== 1'b0)   begin errors++; $display("FAIL reset_sof5: got %b required 0", b5.out_sof); end
    if (b5.out_eof !== 1'b0)   begin errors++; $display("FAIL reset_eof5: got %b required 0", b5.out_eof); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Four frames with no SOF except the third; mode only takes effect there.
  task automatic test_back_to_back();
    int n_sof, n_eof, exp_edge;
    bit bad;
    frame_q.delete(); exp_q.delete(); obs5.delete(); beats5.delete();
    for (int i = 0; i < 4 * W5 * H5; i++) frame_q.push_back(int'($urandom_range(255)));
    drive(1'b1, 1'b0, 1'b0, 25, 0 * W5 * H5, W5 * H5);
    drive(1'b1, 1'b0, 1'b0, 25, 1 * W5 * H5, W5 * H5);
    drive(1'b1, 1'b1, 1'b1, 25, 2 * W5 * H5, W5 * H5);
    drive(1'b1, 1'b1, 1'b0, 25, 3 * W5 * H5, W5 * H5);
    repeat (4) @(negedge clk);
    for (int f = 0; f < 4; f++) build_expected(W5, H5, K5, f >= 2, f * W5 * H5, W5 * H5);
    checks++;
    if (obs5.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_count: got %0d outputs, required %0d", obs5.size(), exp_q.size());
    end
    n_sof = 0; n_eof = 0;
    for (int i = 0; i < exp_q.size() && i < obs5.size(); i++) begin
      exp_edge = (exp_q[i].idx < beats5.size()) ? beats5[exp_q[i].idx] + 1 : -1;
      bad = obs5[i].data !== exp_q[i].data || obs5[i].sof !== exp_q[i].sof ||
            obs5[i].eof !== exp_q[i].eof || obs5[i].edge_n !== exp_edge;
      checks++;
      if (bad) errors++;
      n_sof += int'(obs5[i].sof); n_eof += int'(obs5[i].eof);
      $display("b2b out%0d: data=%0d sof=%0b eof=%0b t=%0d / req %0d %0b %0b t=%0d%s", i,
               obs5[i].data, obs5[i].sof, obs5[i].eof, obs5[i].edge_n,
               exp_q[i].data, exp_q[i].sof, exp_q[i].eof, exp_edge, bad ? "  FAIL b2b" : "");
    end
    checks += 2;
    if (n_sof != 4) begin errors++; $display("FAIL b2b_sof_count: got %0d required 4", n_sof); end
    if (n_eof != 4) begin errors++; $display("FAIL b2b_eof_count: got %0d required 4", n_eof); end
  endtask

  task automatic test_impulse();
    int fg, n_fg, exp_edge;
    bit bad;
    for (int md = 0; md < 2; md++) begin
      fg = (md == 0) ? 200 : 10;
      frame_q.delete(); exp_q.delete(); obs3.delete(); beats3.delete();
      for (int i = 0; i < W3 * H3; i++) frame_q.push_back((md == 0) ? 0 : 255);
      frame_q[2 * W3 + 3] = fg;
      drive(1'b0, 1'(md), 1'b1, 0, 0, W3 * H3);
      repeat (4) @(negedge clk);
      build_expected(W3, H3, K3, 1'(md), 0, W3 * H3);
      checks++;
      if (obs3.size() != 24) begin
        errors++; $display("FAIL impulse_count md=%0d: got %0d outputs, required 24", md, obs3.size());
      end
      n_fg = 0;
      for (int i = 0; i < exp_q.size() && i < obs3.size(); i++) begin
        exp_edge = (exp_q[i].idx < beats3.size()) ? beats3[exp_q[i].idx] + 1 : -1;
        bad = obs3[i].data !== exp_q[i].data || obs3[i].sof !== exp_q[i].sof ||
              obs3[i].eof !== exp_q[i].eof || obs3[i].edge_n !== exp_edge;
        checks++;
        if (bad) errors++;
        if (obs3[i].data == fg) n_fg++;
        $display("impulse md=%0d out%0d: data=%0d sof=%0b eof=%0b t=%0d / req %0d %0b %0b t=%0d%s", md, i,
                 obs3[i].data, obs3[i].sof, obs3[i].eof, obs3[i].edge_n,
                 exp_q[i].data, exp_q[i].sof, exp_q[i].eof, exp_edge, bad ? "  FAIL impulse" : "");
      end
      checks++;
      if (n_fg != 9) begin errors++; $display("FAIL impulse_region md=%0d: got %0d hits, required 9", md, n_fg); end
    end
  endtask

  task automatic test_gapped();
    int exp_edge;
    bit bad;
    frame_q.delete(); exp_q.delete(); obs3.delete(); beats3.delete();
    for (int r = 0; r < H3; r++)
      for (int c = 0; c < W3; c++) frame_q.push_back(r * 8 + c);
    drive(1'b0, 1'b0, 1'b1, 50, 0, W3 * H3);
    repeat (4) @(negedge clk);
    build_expected(W3, H3, K3, 1'b0, 0, W3 * H3);
    checks++;
    if (obs3.size() != 24) begin errors++; $display("FAIL gapped_count: got %0d outputs, required 24", obs3.size()); end
    for (int i = 0; i < exp_q.size() && i < obs3.size(); i++) begin
      exp_edge = (exp_q[i].idx < beats3.size()) ? beats3[exp_q[i].idx] + 1 : -1;
      bad = obs3[i].data !== exp_q[i].data || obs3[i].data !== exp_q[i].idx ||
            obs3[i].sof !== exp_q[i].sof || obs3[i].eof !== exp_q[i].eof || obs3[i].edge_n !== exp_edge;
      checks++;
      if (bad) errors++;
      $display("gapped out%0d: data=%0d sof=%0b eof=%0b t=%0d / req %0d %0b %0b t=%0d%s", i,
               obs3[i].data, obs3[i].sof, obs3[i].eof, obs3[i].edge_n,
               exp_q[i].data, exp_q[i].sof, exp_q[i].eof, exp_edge, bad ? "  FAIL gapped" : "");
    end
  endtask

  // 20 beats of one frame, then a new SOF frame in erode mode.
  task automatic test_sof_resync();
    int exp_edge;
    bit bad;
    frame_q.delete(); exp_q.delete(); obs3.delete(); beats3.delete();
    for (int i = 0; i < 20 + W3 * H3; i++) frame_q.push_back(int'($urandom_range(255)));
    drive(1'b0, 1'b0, 1'b1, 30, 0, 20);
    drive(1'b0, 1'b1, 1'b1, 30, 20, W3 * H3);
    repeat (4) @(negedge clk);
    build_expected(W3, H3, K3, 1'b0, 0, 20);
    build_expected(W3, H3, K3, 1'b1, 20, W3 * H3);
    checks++;
    if (obs3.size() != exp_q.size()) begin
      errors++; $display("FAIL resync_count: got %0d outputs, required %0d", obs3.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs3.size(); i++) begin
      exp_edge = (exp_q[i].idx < beats3.size()) ? beats3[exp_q[i].idx] + 1 : -1;
      bad = obs3[i].data !== exp_q[i].data || obs3[i].sof !== exp_q[i].sof ||
            obs3[i].eof !== exp_q[i].eof || obs3[i].edge_n !== exp_edge;
      checks++;
      if (bad) errors++;
      $display("resync out%0d: data=%0d sof=%0b eof=%0b t=%0d / req %0d %0b %0b t=%0d%s", i,
               obs3[i].data, obs3[i].sof, obs3[i].eof, obs3[i].edge_n,
               exp_q[i].data, exp_q[i].sof, exp_q[i].eof, exp_edge, bad ? "  FAIL resync" : "");
    end
  endtask

  task automatic test_reset_midframe();
    int exp_edge;
    bit bad;
    frame_q.delete();
    for (int i = 0; i < W3 * H3; i++) frame_q.push_back(int'($urandom_range(255)));
    drive(1'b0, 1'b0, 1'b1, 0, 0, 28);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks += 4;
    if (b3.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b required 0", b3.out_valid); end
    if (b3.out_data !== 8'd0)  begin errors++; $display("FAIL midrst_data: got %0d required 0", b3.out_data); end
    if (b3.out_sof !== 1'b0)   begin errors++; $display("FAIL midrst_sof: got %b required 0", b3.out_sof); end
    if (b3.out_eof !== 1'b0)   begin errors++; $display("FAIL midrst_eof: got %b required 0", b3.out_eof); end
    @(negedge clk);
    checks++;
    if (b3.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_drain: got %b required 0", b3.out_valid); end
    frame_q.delete(); exp_q.delete(); obs3.delete(); beats3.delete();
    for (int i = 0; i < W3 * H3; i++) frame_q.push_back(int'($urandom_range(255)));
    drive(1'b0, 1'b1, 1'b1, 20, 0, W3 * H3);
    repeat (4) @(negedge clk);
    build_expected(W3, H3, K3, 1'b1, 0, W3 * H3);
    checks++;
    if (obs3.size() != 24) begin errors++; $display("FAIL midrst_count: got %0d outputs, required 24", obs3.size()); end
    for (int i = 0; i < exp_q.size() && i < obs3.size(); i++) begin
      exp_edge = (exp_q[i].idx < beats3.size()) ? beats3[exp_q[i].idx] + 1 : -1;
      bad = obs3[i].data !== exp_q[i].data || obs3[i].sof !== exp_q[i].sof ||
            obs3[i].eof !== exp_q[i].eof || obs3[i].edge_n !== exp_edge;
      checks++;
      if (bad) errors++;
      $display("midrst out%0d: data=%0d sof=%0b eof=%0b t=%0d / req %0d %0b %0b t=%0d%s", i,
               obs3[i].data, obs3[i].sof, obs3[i].eof, obs3[i].edge_n,
               exp_q[i].data, exp_q[i].sof, exp_q[i].eof, exp_edge, bad ? "  FAIL midrst" : "");
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL idle_flags: got %0d flagged idle cycles, required 0", stray); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_impulse();
    test_gapped();
    test_sof_resync();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
